// File: rtl/kronos_types.sv
// Shared Kronos bus-master types: DMA FSM state encoding and bus constants.
package kronos_types;

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StWrReq,
      StGap,
      StDone
   } dma_state_e;

   localparam logic [3:0] DMA_MASK_WORD = 4'b1111;

   function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
      return addr_lsbs == 2'b00;
   endfunction

endpackage

// File: rtl/kronos_dma_master.sv
// Serial word-copy bus master: reads one word, writes it back out, repeats cfg_len times.
// Drives the same req/ack port set a core LSU presents to the memory arbiter.
module kronos_dma_master
   import kronos_types::*;
#(
   parameter int unsigned LEN_W      = 16,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rstz,
   input  logic             cfg_start,
   input  logic [31:0]      cfg_src,
   input  logic [31:0]      cfg_dst,
   input  logic [LEN_W-1:0] cfg_len,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      data_addr,
   output logic [31:0]      data_wr_data,
   output logic [3:0]       data_mask,
   output logic             data_wr_en,
   output logic             data_req,
   input  logic [31:0]      data_rd_data,
   input  logic             data_ack
);

   // Gap counter counts down to zero, so it is loaded with one less than the gap length.
   localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   dma_state_e       state_q;
   logic [31:0]      src_q;
   logic [31:0]      dst_q;
   logic [LEN_W-1:0] rem_q;
   logic [31:0]      word_q;
   logic [31:0]      addr_q;
   logic             wr_en_q;
   logic             req_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;
   logic [3:0]       gap_cnt_q;
   logic             gap_to_wr_q;

   always_ff @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         state_q     <= StIdle;
         src_q       <= '0;
         dst_q       <= '0;
         rem_q       <= '0;
         word_q      <= '0;
         addr_q      <= '0;
         wr_en_q     <= 1'b0;
         req_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         gap_cnt_q   <= '0;
         gap_to_wr_q <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cfg_start) begin
                  if (!is_word_aligned(cfg_src[1:0]) || !is_word_aligned(cfg_dst[1:0])) begin
                     error_q <= 1'b1;
                  end else if (cfg_len == '0) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     src_q   <= cfg_src;
                     dst_q   <= cfg_dst;
                     rem_q   <= cfg_len;
                     addr_q  <= cfg_src;
                     wr_en_q <= 1'b0;
                     req_q   <= 1'b1;
                     busy_q  <= 1'b1;
                     state_q <= StRdReq;
                  end
               end
            end

            StRdReq: begin
               if (req_q && data_ack) begin
                  word_q <= data_rd_data;
                  if (GAP_CYCLES > 0) begin
                     req_q       <= 1'b0;
                     gap_cnt_q   <= GAP_LOAD;
                     gap_to_wr_q <= 1'b1;
                     state_q     <= StGap;
                  end else begin
                     // The ack cycle itself is the one mandatory idle cycle between requests.
                     addr_q  <= dst_q;
                     wr_en_q <= 1'b1;
                     state_q <= StWrReq;
                  end
               end
            end

            StWrReq: begin
               if (req_q && data_ack) begin
                  src_q <= src_q + 32'd4;
                  dst_q <= dst_q + 32'd4;
                  rem_q <= rem_q - LEN_W'(1);
                  if (rem_q == LEN_W'(1)) begin
                     req_q   <= 1'b0;
                     wr_en_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else if (GAP_CYCLES > 0) begin
                     req_q       <= 1'b0;
                     gap_cnt_q   <= GAP_LOAD;
                     gap_to_wr_q <= 1'b0;
                     state_q     <= StGap;
                  end else begin
                     addr_q  <= src_q + 32'd4;
                     wr_en_q <= 1'b0;
                     state_q <= StRdReq;
                  end
               end
            end

            StGap: begin
               if (gap_cnt_q == '0) begin
                  req_q <= 1'b1;
                  if (gap_to_wr_q) begin
                     addr_q  <= dst_q;
                     wr_en_q <= 1'b1;
                     state_q <= StWrReq;
                  end else begin
                     addr_q  <= src_q;
                     wr_en_q <= 1'b0;
                     state_q <= StRdReq;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q - 4'd1;
               end
            end

            StDone: begin
               state_q <= StIdle;
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Request drops combinationally in the ack cycle so the responder never sees a repeat.
   assign data_req     = req_q & ~data_ack;
   assign data_addr    = addr_q;
   assign data_wr_data = word_q;
   assign data_wr_en   = wr_en_q;
   assign data_mask    = DMA_MASK_WORD;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;

endmodule

// File: tb/tb_kronos_dma_master.sv
// Bench for kronos_dma_master: memory responder with optional random ack delay,
// scoreboard of expected bus transactions checked by a negedge monitor.
module tb_kronos_dma_master;
   import kronos_types::*;

   localparam int unsigned LEN_W = 16;

   logic             clk = 1'b0;
   logic             rstz = 1'b1;
   logic             cfg_start = 1'b0;
   logic [31:0]      cfg_src = '0;
   logic [31:0]      cfg_dst = '0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             busy, done, error;
   logic [31:0]      data_addr, data_wr_data, data_rd_data;
   logic [3:0]       data_mask;
   logic             data_wr_en, data_req, data_ack;
   logic             resp_ack;
   logic             stray_ack = 1'b0;

   assign data_ack = resp_ack | stray_ack;

   always #5 clk = ~clk;

   kronos_dma_master #(
      .LEN_W      (LEN_W),
      .GAP_CYCLES (0)
   ) dut (
      .clk          (clk),
      .rstz         (rstz),
      .cfg_start    (cfg_start),
      .cfg_src      (cfg_src),
      .cfg_dst      (cfg_dst),
      .cfg_len      (cfg_len),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .data_addr    (data_addr),
      .data_wr_data (data_wr_data),
      .data_mask    (data_mask),
      .data_wr_en   (data_wr_en),
      .data_req     (data_req),
      .data_rd_data (data_rd_data),
      .data_ack     (data_ack)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   int unsigned start_cyc = 0;
   int unsigned done_cyc = 0;
   int          done_cnt = 0;
   int          req_cycles = 0;
   int          busy_lows = 0;

   logic [31:0] mem [0:1023];
   int unsigned wait_cnt;
   bit          delay_en = 1'b0;
   logic        pre_we = 1'b0;
   logic [9:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Responder: acks wait_cnt cycles after seeing a request; reads valid in the ack cycle.
   always @(posedge clk or negedge rstz) begin
      if (!rstz) begin
         resp_ack     <= 1'b0;
         data_rd_data <= '0;
         wait_cnt     <= 0;
      end else begin
         if (pre_we) mem[pre_idx] <= pre_val;
         if (resp_ack) begin
            resp_ack <= 1'b0;
         end else if (data_req) begin
            if (wait_cnt == 0) begin
               resp_ack <= 1'b1;
               if (data_wr_en) mem[data_addr[11:2]] <= data_wr_data;
               else data_rd_data <= mem[data_addr[11:2]];
               wait_cnt <= delay_en ? $urandom_range(5, 0) : 0;
            end else begin
               wait_cnt <= wait_cnt - 1;
            end
         end
      end
   end

   // Monitor: stability through ack, req drop in ack cycle, scoreboard compare.
   initial begin
      logic pend;
      txn_t cap;
      txn_t e;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstz) begin
            pend = 1'b0;
         end else begin
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (!busy && !done) busy_lows++;
            if (data_req) begin
               req_cycles++;
               check("mask", 32'(data_mask), 32'hF);
            end
            if (data_req && !pend) begin
               pend = 1'b1;
               cap  = '{we: data_wr_en, addr: data_addr, data: data_wr_data};
            end else if (pend && (data_req || data_ack)) begin
               check("hold_addr", data_addr, cap.addr);
               check("hold_wr_en", 32'(data_wr_en), 32'(cap.we));
               if (cap.we) check("hold_wr_data", data_wr_data, cap.data);
            end
            if (pend && data_ack) begin
               check("req_drop_on_ack", 32'(data_req), 32'h0);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_txn: got addr %h we %0d, required none",
                           data_addr, data_wr_en);
               end else begin
                  e = exp_q.pop_front();
                  check("txn_wr_en", 32'(data_wr_en), 32'(e.we));
                  check("txn_addr", data_addr, e.addr);
                  if (e.we) check("txn_wr_data", data_wr_data, e.data);
               end
               pend = 1'b0;
            end
         end
      end
   end

   task automatic preload(input logic [31:0] addr, input logic [31:0] val);
      pre_we  = 1'b1;
      pre_idx = addr[11:2];
      pre_val = val;
      @(posedge clk);
      #1;
      pre_we = 1'b0;
   endtask

   task automatic push_rd(input logic [31:0] addr);
      exp_q.push_back('{we: 1'b0, addr: addr, data: 32'h0});
   endtask

   task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back('{we: 1'b1, addr: addr, data: data});
   endtask

   task automatic start(input logic [31:0] s, input logic [31:0] d, input int l);
      cfg_src   = s;
      cfg_dst   = d;
      cfg_len   = LEN_W'(l);
      cfg_start = 1'b1;
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input int base, input int max_cyc, input string name);
      int i;
      i = 0;
      while (done_cnt == base && i < max_cyc) begin
         @(posedge clk);
         #1;
         i++;
      end
      check({name, "_done_seen"}, 32'(done_cnt != base), 32'h1);
   endtask

   initial begin
      int base;
      int rbase;
      int blow;

      #1 rstz = 1'b0;
      #2;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_error", 32'(error), 32'h0);
      check("rst_req", 32'(data_req), 32'h0);
      check("rst_addr", data_addr, 32'h0);
      check("rst_wr_en", 32'(data_wr_en), 32'h0);
      check("rst_wr_data", data_wr_data, 32'h0);
      idle(2);
      rstz = 1'b1;
      idle(1);

      preload(32'h100, 32'hA);
      preload(32'h104, 32'hB);
      preload(32'h108, 32'hC);

      // Zero-wait 3-word copy: fixed schedule, done in cycle 13 after start.
      push_rd(32'h100); push_wr(32'h200, 32'hA);
      push_rd(32'h104); push_wr(32'h204, 32'hB);
      push_rd(32'h108); push_wr(32'h208, 32'hC);
      base = done_cnt;
      start(32'h100, 32'h200, 3);
      blow = busy_lows;
      wait_done(base, 40, "copy3");
      check("copy3_done_cycle", done_cyc - start_cyc + 1, 32'd13);
      check("copy3_busy_held", 32'(busy_lows - blow), 32'h0);
      idle(4);
      check("copy3_done_once", 32'(done_cnt - base), 32'h1);
      check("copy3_sb_drained", 32'(exp_q.size()), 32'h0);
      check("copy3_mem0", mem[10'h080], 32'hA);
      check("copy3_mem2", mem[10'h082], 32'hC);

      // Random 0..5 cycle ack delay.
      preload(32'h300, 32'h1111_0001);
      preload(32'h304, 32'h2222_0002);
      preload(32'h308, 32'h3333_0003);
      preload(32'h30C, 32'h4444_0004);
      push_rd(32'h300); push_wr(32'h400, 32'h1111_0001);
      push_rd(32'h304); push_wr(32'h404, 32'h2222_0002);
      push_rd(32'h308); push_wr(32'h408, 32'h3333_0003);
      push_rd(32'h30C); push_wr(32'h40C, 32'h4444_0004);
      delay_en = 1'b1;
      base = done_cnt;
      start(32'h300, 32'h400, 4);
      wait_done(base, 300, "delay4");
      delay_en = 1'b0;
      idle(8);
      check("delay4_sb_drained", 32'(exp_q.size()), 32'h0);
      check("delay4_mem0", mem[10'h100], 32'h1111_0001);
      check("delay4_mem3", mem[10'h103], 32'h4444_0004);

      // Misaligned source and destination: error pulse only.
      rbase = req_cycles;
      base  = done_cnt;
      start(32'h102, 32'h200, 1);
      check("mis_src_error", 32'(error), 32'h1);
      check("mis_src_busy", 32'(busy), 32'h0);
      idle(1);
      check("mis_src_error_pulse", 32'(error), 32'h0);
      start(32'h100, 32'h201, 1);
      check("mis_dst_error", 32'(error), 32'h1);
      idle(5);
      check("mis_no_req", 32'(req_cycles - rbase), 32'h0);
      check("mis_no_done", 32'(done_cnt - base), 32'h0);

      // Zero length: done only.
      start(32'h100, 32'h200, 0);
      check("len0_done", 32'(done), 32'h1);
      check("len0_busy", 32'(busy), 32'h0);
      check("len0_error", 32'(error), 32'h0);
      idle(5);
      check("len0_no_req", 32'(req_cycles - rbase), 32'h0);
      check("len0_done_once", 32'(done_cnt - base), 32'h1);

      // Stray ack while idle is ignored.
      stray_ack = 1'b1;
      idle(1);
      stray_ack = 1'b0;
      idle(3);
      check("stray_no_req", 32'(req_cycles - rbase), 32'h0);
      check("stray_busy", 32'(busy), 32'h0);

      // Second start mid-transfer is ignored.
      preload(32'h500, 32'h5555_AAAA);
      preload(32'h504, 32'h6666_BBBB);
      push_rd(32'h500); push_wr(32'h600, 32'h5555_AAAA);
      push_rd(32'h504); push_wr(32'h604, 32'h6666_BBBB);
      base = done_cnt;
      start(32'h500, 32'h600, 2);
      idle(2);
      start(32'h700, 32'h800, 5);
      check("restart_no_error", 32'(error), 32'h0);
      wait_done(base, 40, "restart");
      idle(10);
      check("restart_done_once", 32'(done_cnt - base), 32'h1);
      check("restart_sb_drained", 32'(exp_q.size()), 32'h0);
      check("restart_mem1", mem[10'h181], 32'h6666_BBBB);

      // Source address wraps past 0xFFFFFFFC.
      preload(32'hFFFF_FFFC, 32'hDEAD_0001);
      preload(32'h0000_0000, 32'hBEEF_0002);
      push_rd(32'hFFFF_FFFC); push_wr(32'h900, 32'hDEAD_0001);
      push_rd(32'h0000_0000); push_wr(32'h904, 32'hBEEF_0002);
      base = done_cnt;
      start(32'hFFFF_FFFC, 32'h900, 2);
      wait_done(base, 40, "wrap");
      idle(2);
      check("wrap_sb_drained", 32'(exp_q.size()), 32'h0);
      check("wrap_mem1", mem[10'h241], 32'hBEEF_0002);

      // Reset while a write is pending.
      push_rd(32'h100); push_wr(32'hA00, 32'hA);
      base = done_cnt;
      start(32'h100, 32'hA00, 3);
      for (int i = 0; i < 40 && !(data_req && data_wr_en); i++) idle(1);
      check("rst_mid_in_wr", 32'(data_req && data_wr_en), 32'h1);
      #2 rstz = 1'b0;
      #1;
      check("rst_mid_req", 32'(data_req), 32'h0);
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_addr", data_addr, 32'h0);
      check("rst_mid_wr_en", 32'(data_wr_en), 32'h0);
      check("rst_mid_wr_data", data_wr_data, 32'h0);
      exp_q.delete();
      idle(3);
      rstz = 1'b1;
      idle(3);
      check("rst_mid_no_done", 32'(done_cnt - base), 32'h0);
      push_rd(32'h104); push_wr(32'hB00, 32'hB);
      start(32'h104, 32'hB00, 1);
      wait_done(base, 40, "post_rst");
      idle(2);
      check("post_rst_sb_drained", 32'(exp_q.size()), 32'h0);
      check("post_rst_mem", mem[10'h2C0], 32'hB);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule
